bcd_minsec_counter: RTL and testbench



---
 rtl/bcd_minsec_counter_if.sv | 20 ++
 rtl/bcd_minsec_counter.sv | 103 ++++++++++
 tb/tb_bcd_minsec_counter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_minsec_counter_if.sv
// Control and display bus of the MM:SS timekeeper: run/clear/set controls in,
// packed BCD digits and event pulses out.
interface bcd_minsec_counter_if;
  logic        run;
  logic        clr;
  logic        inc_min;
  logic [15:0] digits;
  logic        sec_tick;
  logic        rollover;

  modport master (
    output run, clr, inc_min,
    input  digits, sec_tick, rollover
  );

  modport slave (
    input  run, clr, inc_min,
    output digits, sec_tick, rollover
  );
endinterface

// File: rtl/bcd_minsec_counter.sv
// MM:SS timekeeper: divides clk to a 1 Hz tick and counts minutes/seconds as
// four packed BCD digits for the downstream 7-segment scanner.
module bcd_minsec_counter #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  bcd_minsec_counter_if.slave  bus
);

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd60_t;

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

  // One step of a 00..59 BCD pair; tens wrap 5 -> 0.
  function automatic bcd60_t bcd60_inc(input bcd60_t v);
    bcd60_t r;
    r = v;
    if (v.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = (v.tens == 4'd5) ? 4'd0 : v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

  function automatic logic bcd60_is_max(input bcd60_t v);
    return (v.tens == 4'd5) && (v.ones == 4'd9);
  endfunction

  logic [CNT_W-1:0] presc_q, presc_d;
  bcd60_t           sec_q, sec_d;
  bcd60_t           min_q, min_d;
  logic             sec_tick_q, sec_tick_d;
  logic             rollover_q, rollover_d;
  logic             tick;
  logic             min_carry;

  assign tick      = bus.run && (presc_q == PRESC_LAST);
  assign min_carry = tick && bcd60_is_max(sec_q);

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; that is what keeps this block free of latches.
  always_comb begin
    presc_d    = presc_q;
    sec_d      = sec_q;
    min_d      = min_q;
    sec_tick_d = 1'b0;
    rollover_d = 1'b0;

    if (bus.clr) begin
      // Clear discards any tick and inc_min sampled on the same edge.
      presc_d = '0;
      sec_d   = '0;
      min_d   = '0;
    end else begin
      if (bus.run) begin
        presc_d = tick ? '0 : presc_q + CNT_W'(1);
      end

      if (tick) begin
        sec_d      = bcd60_inc(sec_q);
        sec_tick_d = 1'b1;
        // Wrap is judged on the tick alone; a coincident inc_min does not mask it.
        rollover_d = bcd60_is_max(sec_q) && bcd60_is_max(min_q);
      end

      unique case ({min_carry, bus.inc_min})
        2'b11:        min_d = bcd60_inc(bcd60_inc(min_q));
        2'b10, 2'b01: min_d = bcd60_inc(min_q);
        default:      min_d = min_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them sample
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q    <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      sec_tick_q <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      sec_tick_q <= sec_tick_d;
      rollover_q <= rollover_d;
    end
  end

  assign bus.digits   = {min_q, sec_q};
  assign bus.sec_tick = sec_tick_q;
  assign bus.rollover = rollover_q;

endmodule

// File: tb/tb_bcd_minsec_counter.sv
// Bench for bcd_minsec_counter: directed scenarios plus random run/clr/inc_min
// traffic checked against a total-seconds model of the clock.
module tb_bcd_minsec_counter;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 3;

  logic clk;
  logic reset;

  bcd_minsec_counter_if bus();

  bcd_minsec_counter #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: elapsed time as seconds past 00:00 plus a divider phase.
  int m_t;
  int m_p;
  bit m_tick;
  bit m_roll;

  function automatic logic [15:0] to_bcd(input int t);
    int m;
    int s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    m_t    = 0;
    m_p    = 0;
    m_tick = 1'b0;
    m_roll = 1'b0;
  endtask

  // Advance model by one edge using the inputs currently applied, then clock.
  task automatic cycle();
    bit tk;
    if (bus.clr) begin
      model_reset();
    end else begin
      tk     = bus.run && (m_p == TICK_DIV - 1);
      if (bus.run) m_p = (m_p + 1) % TICK_DIV;
      m_tick = tk;
      m_roll = tk && (m_t == 3599);
      if (tk) m_t = (m_t + 1) % 3600;
      if (bus.inc_min) m_t = (((m_t / 60) + 1) % 60) * 60 + (m_t % 60);
    end
    @(posedge clk);
    #1;
  endtask

  // Clear, set minutes, then run to the target; leaves the divider one edge from a tick.
  task automatic goto_time(input int target);
    bus.clr = 1'b1; bus.inc_min = 1'b0; bus.run = 1'b0;
    cycle();
    bus.clr = 1'b0; bus.inc_min = 1'b1;
    repeat (target / 60) cycle();
    bus.inc_min = 1'b0; bus.run = 1'b1;
    for (int i = 0; i < 400 && m_t != target; i++) cycle();
    checks++;
    if (bus.digits !== to_bcd(target)) begin
      failures++;
      $display("FAIL goto_time: digits got %h expected %h", bus.digits, to_bcd(target));
    end
    repeat (TICK_DIV - 1) cycle();
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.run = 1'b1; bus.clr = 1'b0; bus.inc_min = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.digits !== 16'h0000) begin
      failures++; $display("FAIL reset_digits: got %h expected 0000", bus.digits);
    end
    checks++;
    if (bus.sec_tick !== 1'b0) begin
      failures++; $display("FAIL reset_sec_tick: got %b expected 0", bus.sec_tick);
    end
    checks++;
    if (bus.rollover !== 1'b0) begin
      failures++; $display("FAIL reset_rollover: got %b expected 0", bus.rollover);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_run();
    int ticks = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (bus.sec_tick === 1'b1) ticks++;
      checks++;
      if (bus.sec_tick !== ((i % TICK_DIV) == TICK_DIV - 1)) begin
        failures++; $display("FAIL run_tick_cycle%0d: got %b", i, bus.sec_tick);
      end
    end
    checks++;
    if (ticks !== 3) begin
      failures++; $display("FAIL run_tick_count: got %0d expected 3", ticks);
    end
    checks++;
    if (bus.digits !== 16'h0003) begin
      failures++; $display("FAIL run_digits: got %h expected 0003", bus.digits);
    end
  endtask

  task automatic test_carry();
    goto_time(59);
    cycle();
    checks++;
    if (bus.digits !== 16'h0100 || bus.sec_tick !== 1'b1 || bus.rollover !== 1'b0) begin
      failures++;
      $display("FAIL sec_carry: got %h/%b/%b expected 0100/1/0", bus.digits, bus.sec_tick, bus.rollover);
    end
  endtask

  task automatic test_wrap();
    goto_time(3599);
    cycle();
    checks++;
    if (bus.digits !== 16'h0000 || bus.sec_tick !== 1'b1 || bus.rollover !== 1'b1) begin
      failures++;
      $display("FAIL full_wrap: got %h/%b/%b expected 0000/1/1", bus.digits, bus.sec_tick, bus.rollover);
    end
    cycle();
    checks++;
    if (bus.sec_tick !== 1'b0 || bus.rollover !== 1'b0) begin
      failures++;
      $display("FAIL wrap_pulse_width: got %b/%b expected 0/0", bus.sec_tick, bus.rollover);
    end
  endtask

  task automatic test_hold();
    int seen = 0;
    goto_time(100);
    repeat (3) cycle();  // tick to 01:41, then divider at 2
    bus.run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (bus.sec_tick !== 1'b0 || bus.digits !== 16'h0141) begin
        failures++;
        $display("FAIL hold_cycle%0d: got %h/%b expected 0141/0", i, bus.digits, bus.sec_tick);
      end
    end
    bus.run = 1'b1;
    for (int i = 0; i < 3 * TICK_DIV; i++) begin
      cycle();
      if (bus.sec_tick === 1'b1) begin seen = i + 1; break; end
    end
    checks++;
    if (seen !== TICK_DIV - 2) begin
      failures++; $display("FAIL hold_resume_latency: got %0d expected %0d", seen, TICK_DIV - 2);
    end
    checks++;
    if (bus.digits !== 16'h0142) begin
      failures++; $display("FAIL hold_resume_digits: got %h expected 0142", bus.digits);
    end
  endtask

  task automatic test_inc_min();
    goto_time(570);
    bus.run = 1'b0; bus.inc_min = 1'b1;
    cycle();
    bus.inc_min = 1'b0;
    checks++;
    if (bus.digits !== 16'h1030 || bus.sec_tick !== 1'b0) begin
      failures++; $display("FAIL inc_0930: got %h/%b expected 1030/0", bus.digits, bus.sec_tick);
    end

    goto_time(3550);
    bus.run = 1'b0; bus.inc_min = 1'b1;
    cycle();
    bus.inc_min = 1'b0;
    checks++;
    if (bus.digits !== 16'h0010 || bus.rollover !== 1'b0 || bus.sec_tick !== 1'b0) begin
      failures++;
      $display("FAIL inc_5910: got %h/%b/%b expected 0010/0/0", bus.digits, bus.sec_tick, bus.rollover);
    end

    goto_time(3539);
    bus.inc_min = 1'b1;
    cycle();
    bus.inc_min = 1'b0;
    checks++;
    if (bus.digits !== 16'h0000 || bus.sec_tick !== 1'b1 || bus.rollover !== 1'b0) begin
      failures++;
      $display("FAIL inc_tick_5859: got %h/%b/%b expected 0000/1/0", bus.digits, bus.sec_tick, bus.rollover);
    end

    goto_time(3599);
    bus.inc_min = 1'b1;
    cycle();
    bus.inc_min = 1'b0;
    checks++;
    if (bus.digits !== 16'h0100 || bus.sec_tick !== 1'b1 || bus.rollover !== 1'b1) begin
      failures++;
      $display("FAIL inc_tick_5959: got %h/%b/%b expected 0100/1/1", bus.digits, bus.sec_tick, bus.rollover);
    end
  endtask

  task automatic test_clear();
    int seen = 0;
    goto_time(754);
    bus.clr = 1'b1; bus.inc_min = 1'b1;
    cycle();
    bus.clr = 1'b0; bus.inc_min = 1'b0;
    checks++;
    if (bus.digits !== 16'h0000 || bus.sec_tick !== 1'b0 || bus.rollover !== 1'b0) begin
      failures++;
      $display("FAIL clr_priority: got %h/%b/%b expected 0000/0/0", bus.digits, bus.sec_tick, bus.rollover);
    end
    for (int i = 0; i < 3 * TICK_DIV; i++) begin
      cycle();
      if (bus.sec_tick === 1'b1) begin seen = i + 1; break; end
    end
    checks++;
    if (seen !== TICK_DIV) begin
      failures++; $display("FAIL clr_prescaler_restart: got %0d expected %0d", seen, TICK_DIV);
    end
  endtask

  task automatic test_async_reset();
    int seen = 0;
    goto_time(2000);
    cycle();  // this edge ticks: 33:21 with sec_tick high
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bus.digits !== 16'h0000 || bus.sec_tick !== 1'b0 || bus.rollover !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got %h/%b/%b expected 0000/0/0", bus.digits, bus.sec_tick, bus.rollover);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3 * TICK_DIV; i++) begin
      cycle();
      if (bus.sec_tick === 1'b1) begin seen = i + 1; break; end
    end
    checks++;
    if (seen !== TICK_DIV) begin
      failures++; $display("FAIL reset_prescaler_restart: got %0d expected %0d", seen, TICK_DIV);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      bus.run     = ($urandom % 8) != 0;
      bus.clr     = ($urandom % 200) == 0;
      bus.inc_min = ($urandom % 12) == 0;
      cycle();
      checks++;
      if (bus.digits !== to_bcd(m_t) || bus.sec_tick !== m_tick || bus.rollover !== m_roll) begin
        failures++;
        $display("FAIL random_cycle%0d: got %h/%b/%b expected %h/%b/%b", i, bus.digits,
                 bus.sec_tick, bus.rollover, to_bcd(m_t), m_tick, m_roll);
      end
    end
    bus.clr = 1'b0; bus.inc_min = 1'b0; bus.run = 1'b1;
  endtask

  initial begin
    test_reset();
    test_run();
    test_carry();
    test_wrap();
    test_hold();
    test_inc_min();
    test_clear();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
